// File: rtl/sys_array_pkg.sv
// Shared types for the systolic-array result drainer: FSM state encoding and
// the result element width derived from the operand width.
package sys_array_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int RES_W_DEF      = 2 * DATA_WIDTH_DEF;

  function automatic int res_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/sys_array_drainer.sv
// De-skews the diagonal wavefront leaving a systolic array into whole result
// rows and streams them out with valid/ready while capture keeps running.
module sys_array_drainer
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_W_L  = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic signed [ARRAY_W_L-1:0][2*DATA_WIDTH-1:0] in_data,
  output logic signed [ARRAY_W_L-1:0][2*DATA_WIDTH-1:0] out_row,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [15:0]                                   out_row_idx,
  output logic                                          out_last,
  output logic                                          busy,
  output logic                                          start_err
);

  localparam int EW   = res_width(DATA_WIDTH);
  localparam int NOFF = ARRAY_A_W + ARRAY_W_L - 1;
  localparam int KW   = $clog2(NOFF + 1);
  localparam int RW   = $clog2(ARRAY_A_W + 1);

  localparam logic [KW-1:0] K_LAST       = KW'(NOFF - 1);
  localparam logic [KW-1:0] K_FIRST_DONE = KW'(ARRAY_W_L - 1);
  localparam logic [RW-1:0] R_LAST       = RW'(ARRAY_A_W - 1);

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d, k_cur;
  logic [RW-1:0]     rows_avail_q, rows_avail_d;
  logic [RW-1:0]     rd_row_q, rd_row_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              start_err_q, start_err_d;
  logic [15:0]       idx_q, idx_d;
  logic              start_acc, cap, hs, final_hs, row_done;

  logic [ARRAY_A_W-1:0][ARRAY_W_L-1:0][EW-1:0] rowbuf_q;

  always_comb begin
    hs        = out_valid_q & out_ready;
    final_hs  = hs && (state_q == DRAIN) && (rd_row_q == R_LAST);
    start_acc = start && ((state_q == IDLE) || final_hs);
    cap       = start_acc || (state_q == CAPTURE);
    // the accepted start cycle itself is offset 0
    k_cur     = start_acc ? '0 : k_q;
    row_done  = cap && (k_cur >= K_FIRST_DONE) && (k_cur <= K_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_acc) begin
      state_d = (K_LAST == '0) ? DRAIN : CAPTURE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        CAPTURE: if (k_cur == K_LAST) state_d = DRAIN;
        DRAIN:   if (final_hs) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    out_row = '0;
    for (int r = 0; r < ARRAY_A_W; r++)
      if (out_valid_q && (rd_row_q == RW'(r))) out_row = rowbuf_q[r];
  end

  always_comb begin
    k_d          = cap ? k_cur + 1'b1 : k_q;
    rows_avail_d = (start_acc ? '0 : rows_avail_q) + RW'(row_done);
    rd_row_d     = start_acc ? '0 : rd_row_q + RW'(hs);
    // valid looks at next-state counters so a row is shown the cycle after it completes
    out_valid_d  = (rd_row_d < rows_avail_d);
    out_last_d   = out_valid_d && (rd_row_d == R_LAST);
    idx_d        = out_valid_d ? 16'(rd_row_d) : '0;
    start_err_d  = start_err_q | (start & ~start_acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_q          <= '0;
      rows_avail_q <= '0;
      rd_row_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      idx_q        <= '0;
      start_err_q  <= 1'b0;
    end else begin
      k_q          <= k_d;
      rows_avail_q <= rows_avail_d;
      rd_row_q     <= rd_row_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      idx_q        <= idx_d;
      start_err_q  <= start_err_d;
    end
  end

  // column j at offset k carries row k-j; anything outside the matrix is dropped
  always_ff @(posedge clk) begin
    for (int i = 0; i < ARRAY_A_W; i++)
      for (int j = 0; j < ARRAY_W_L; j++)
        if (cap && (k_cur == KW'(i + j))) rowbuf_q[i][j] <= in_data[j];
  end

  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_row_idx = idx_q;
  assign start_err   = start_err_q;

endmodule
